// File: rtl/conv2d_window_gen_vec.sv
// Streaming vectorised line buffer and window generator for the Conv2D MAC array.
// Takes PIX_PER_CLK raster pixels per beat and emits, one cycle later, one
// WIN_SIZE x WIN_SIZE window per lane with causal zero padding (above and left).
module conv2d_window_gen_vec #(
    parameter int DATA_W      = 8,
    parameter int WIN_SIZE    = 3,
    parameter int PIX_PER_CLK = 8,
    parameter int IMG_W       = 64,
    parameter int IMG_H       = 64
) (
    input  logic                                                            clk,
    input  logic                                                            rst,
    input  logic                                                            in_valid,
    input  logic [PIX_PER_CLK-1:0][DATA_W-1:0]                              in_pix,
    output logic                                                            out_valid,
    output logic [PIX_PER_CLK-1:0][WIN_SIZE-1:0][WIN_SIZE-1:0][DATA_W-1:0]  window,
    output logic                                                            out_sof,
    output logic                                                            out_eol,
    output logic                                                            out_eof
);

    localparam int NBEATS = IMG_W / PIX_PER_CLK;
    localparam int CB_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int HIST   = WIN_SIZE - 1;
    localparam int EXT_W  = PIX_PER_CLK + HIST;

    typedef logic [PIX_PER_CLK-1:0][DATA_W-1:0]            beat_t;
    typedef logic [EXT_W-1:0][DATA_W-1:0]                  ext_t;
    typedef logic [WIN_SIZE-1:0][WIN_SIZE-1:0][DATA_W-1:0] win_t;

    // Raster position of the beat currently on in_pix
    logic [CB_W-1:0]  r_cb;
    logic [ROW_W-1:0] r_row;

    // Line memories: r_lb_mem[k] holds row r-1-k, one word per column beat
    beat_t r_lb_mem [WIN_SIZE-1][NBEATS];

    // Rightmost HIST columns of the previous beat, per window row
    logic [WIN_SIZE-1:0][HIST-1:0][DATA_W-1:0] r_hist;

    // Registered outputs
    win_t [PIX_PER_CLK-1:0] r_window;
    logic                   r_out_valid;
    logic                   r_sof;
    logic                   r_eol;
    logic                   r_eof;

    // Combinational datapath
    beat_t [WIN_SIZE-1:0]   w_rows;
    ext_t  [WIN_SIZE-1:0]   w_ext;
    win_t  [PIX_PER_CLK-1:0] w_win;
    logic                   w_first_beat;
    logic                   w_last_beat;
    logic                   w_last_row;

    assign w_first_beat = (r_cb == '0);
    assign w_last_beat  = (r_cb == CB_W'(NBEATS - 1));
    assign w_last_row   = (r_row == ROW_W'(IMG_H - 1));

    // Column-beat and row counters; advance only on valid beats, wrap at frame end
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            r_cb  <= '0;
            r_row <= '0;
        end else if (in_valid) begin
            if (w_last_beat) begin
                r_cb  <= '0;
                r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
            end else begin
                r_cb  <= r_cb + CB_W'(1);
            end
        end
    end

    // Line memory shift: each row moves one memory deeper (read-before-write)
    always_ff @(posedge clk) begin
        // NOTE: the line memories are deliberately not reset; rows not yet written
        // in the current frame are masked by the row counter instead.
        if (!rst && in_valid) begin
            r_lb_mem[0][r_cb] <= in_pix;
            for (int k = 1; k < WIN_SIZE - 1; k++) begin
                r_lb_mem[k][r_cb] <= r_lb_mem[k-1][r_cb];
            end
        end
    end

    // Assemble the WIN_SIZE rows of this beat, masking rows above the image
    always_comb begin
        // NOTE: default every combinational output first so no path infers a latch.
        w_rows             = '0;
        w_rows[WIN_SIZE-1] = in_pix;
        for (int k = 0; k < WIN_SIZE - 1; k++) begin
            if (int'(r_row) >= k + 1) begin
                w_rows[WIN_SIZE-2-k] = r_lb_mem[k][r_cb];
            end
        end
    end

    // Extend each row with history columns on the left; the first beat of a row
    // sees zero history, which provides the left padding
    always_comb begin
        w_ext = '0;
        for (int i = 0; i < WIN_SIZE; i++) begin
            for (int m = 0; m < HIST; m++) begin
                w_ext[i][m] = w_first_beat ? '0 : r_hist[i][m];
            end
            for (int p = 0; p < PIX_PER_CLK; p++) begin
                w_ext[i][HIST+p] = w_rows[i][p];
            end
        end
    end

    // Slice one window per lane out of the extended rows
    always_comb begin
        w_win = '0;
        for (int l = 0; l < PIX_PER_CLK; l++) begin
            for (int i = 0; i < WIN_SIZE; i++) begin
                for (int j = 0; j < WIN_SIZE; j++) begin
                    w_win[l][i][j] = w_ext[i][l+j];
                end
            end
        end
    end

    // Capture the rightmost columns of each row for the next beat of the same row
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
        end else if (in_valid) begin
            for (int i = 0; i < WIN_SIZE; i++) begin
                for (int m = 0; m < HIST; m++) begin
                    r_hist[i][m] <= w_rows[i][PIX_PER_CLK-HIST+m];
                end
            end
        end
    end

    // Output register: windows hold while idle, flags only accompany valid beats
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sof       <= 1'b0;
            r_eol       <= 1'b0;
            r_eof       <= 1'b0;
            r_window    <= '0;
        end else begin
            r_out_valid <= in_valid;
            r_sof       <= in_valid && w_first_beat && (r_row == '0);
            r_eol       <= in_valid && w_last_beat;
            r_eof       <= in_valid && w_last_beat && w_last_row;
            if (in_valid) begin
                r_window <= w_win;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sof   = r_sof;
    assign out_eol   = r_eol;
    assign out_eof   = r_eof;
    assign window    = r_window;

endmodule
